// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - Control, memory-read and status bundle of the FIR MAC sequencer
interface fir_mac_sequencer_if #(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6
);
  logic                    start_i;
  logic                    R_en;
  logic [H_ADDR_WIDTH-1:0] h_addr;
  logic [X_ADDR_WIDTH-1:0] x_addr;
  logic                    mac_en_o;
  logic                    mac_first_o;
  logic                    x_zero_o;
  logic                    y_valid_o;
  logic [X_ADDR_WIDTH-1:0] y_index_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    invalid_i;
  logic                    overflow_i;
  logic                    underflow_i;
  logic                    err_invalid_o;
  logic                    err_overflow_o;
  logic                    err_underflow_o;

  modport master (
    input  start_i, invalid_i, overflow_i, underflow_i,
    output R_en, h_addr, x_addr, mac_en_o, mac_first_o, x_zero_o,
           y_valid_o, y_index_o, busy_o, done_o,
           err_invalid_o, err_overflow_o, err_underflow_o
  );

  modport slave (
    output start_i, invalid_i, overflow_i, underflow_i,
    input  R_en, h_addr, x_addr, mac_en_o, mac_first_o, x_zero_o,
           y_valid_o, y_index_o, busy_o, done_o,
           err_invalid_o, err_overflow_o, err_underflow_o
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - Tap/sample read sequencer with MAC control and y_valid latency pipelines
module fir_mac_sequencer #(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6,
  parameter int NUM_TAPS     = 16,
  parameter int NUM_SAMPLES  = 64,
  parameter int MEM_LATENCY  = 1,
  parameter int DSP_LATENCY  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fir_mac_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [H_ADDR_WIDTH-1:0] LAST_K = H_ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [X_ADDR_WIDTH-1:0] LAST_N = X_ADDR_WIDTH'(NUM_SAMPLES - 1);

  state_e                  state_q, state_d;
  logic [H_ADDR_WIDTH-1:0] k_q, k_d;
  logic [X_ADDR_WIDTH-1:0] n_q, n_d;
  logic [2:0]              err_q, err_d;

  logic [MEM_LATENCY-1:0]  mem_v_q, mem_v_d;
  logic [MEM_LATENCY-1:0]  mem_first_q, mem_first_d;
  logic [MEM_LATENCY-1:0]  mem_last_q, mem_last_d;
  logic [MEM_LATENCY-1:0]  mem_zero_q, mem_zero_d;
  logic [X_ADDR_WIDTH-1:0] mem_n_q [MEM_LATENCY];
  logic [X_ADDR_WIDTH-1:0] mem_n_d [MEM_LATENCY];

  logic [DSP_LATENCY-1:0]  dsp_v_q, dsp_v_d;
  logic [X_ADDR_WIDTH-1:0] dsp_n_q [DSP_LATENCY];
  logic [X_ADDR_WIDTH-1:0] dsp_n_d [DSP_LATENCY];

  logic issue, issue_first, issue_last, issue_zero;
  logic tap_last_out, y_valid;

  // k>n means the sample index wrapped below zero: causal zero padding.
  assign issue       = (state_q == S_RUN);
  assign issue_first = issue && (k_q == '0);
  assign issue_last  = issue && (k_q == LAST_K);
  assign issue_zero  = issue && ({{X_ADDR_WIDTH{1'b0}}, k_q} > {{H_ADDR_WIDTH{1'b0}}, n_q});

  assign tap_last_out = mem_v_q[MEM_LATENCY-1] & mem_last_q[MEM_LATENCY-1];
  assign y_valid      = dsp_v_q[DSP_LATENCY-1];

  always_comb begin
    mem_v_d     = '0;
    mem_first_d = '0;
    mem_last_d  = '0;
    mem_zero_d  = '0;
    for (int i = 0; i < MEM_LATENCY; i++) mem_n_d[i] = '0;
    mem_v_d[0]     = issue;
    mem_first_d[0] = issue_first;
    mem_last_d[0]  = issue_last;
    mem_zero_d[0]  = issue_zero;
    mem_n_d[0]     = n_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      mem_v_d[i]     = mem_v_q[i-1];
      mem_first_d[i] = mem_first_q[i-1];
      mem_last_d[i]  = mem_last_q[i-1];
      mem_zero_d[i]  = mem_zero_q[i-1];
      mem_n_d[i]     = mem_n_q[i-1];
    end
  end

  // Index fields only advance with a valid bit so y_index_o holds between pulses.
  always_comb begin
    dsp_v_d = '0;
    for (int i = 0; i < DSP_LATENCY; i++) dsp_n_d[i] = dsp_n_q[i];
    dsp_v_d[0] = tap_last_out;
    if (tap_last_out) dsp_n_d[0] = mem_n_q[MEM_LATENCY-1];
    for (int i = 1; i < DSP_LATENCY; i++) begin
      dsp_v_d[i] = dsp_v_q[i-1];
      if (dsp_v_q[i-1]) dsp_n_d[i] = dsp_n_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    err_d   = err_q;
    if (y_valid) err_d = err_q | {bus.invalid_i, bus.overflow_i, bus.underflow_i};
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_RUN;
          k_d     = '0;
          n_d     = '0;
          err_d   = '0;
        end
      end
      S_RUN: begin
        // Explicit compare so a full-range tap count still wraps correctly.
        if (k_q == LAST_K) begin
          k_d = '0;
          if (n_q == LAST_N) state_d = S_DRAIN;
          else               n_d = n_q + X_ADDR_WIDTH'(1);
        end else begin
          k_d = k_q + H_ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if ((mem_v_d == '0) && (dsp_v_d == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      err_q       <= '0;
      mem_v_q     <= '0;
      mem_first_q <= '0;
      mem_last_q  <= '0;
      mem_zero_q  <= '0;
      mem_n_q     <= '{default: '0};
      dsp_v_q     <= '0;
      dsp_n_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      err_q       <= err_d;
      mem_v_q     <= mem_v_d;
      mem_first_q <= mem_first_d;
      mem_last_q  <= mem_last_d;
      mem_zero_q  <= mem_zero_d;
      mem_n_q     <= mem_n_d;
      dsp_v_q     <= dsp_v_d;
      dsp_n_q     <= dsp_n_d;
    end
  end

  assign bus.R_en            = issue;
  assign bus.h_addr          = issue ? k_q : '0;
  assign bus.x_addr          = issue ? (n_q - X_ADDR_WIDTH'(k_q)) : '0;
  assign bus.mac_en_o        = mem_v_q[MEM_LATENCY-1];
  assign bus.mac_first_o     = mem_v_q[MEM_LATENCY-1] & mem_first_q[MEM_LATENCY-1];
  assign bus.x_zero_o        = mem_v_q[MEM_LATENCY-1] & mem_zero_q[MEM_LATENCY-1];
  assign bus.y_valid_o       = y_valid;
  assign bus.y_index_o       = dsp_n_q[DSP_LATENCY-1];
  assign bus.busy_o          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done_o          = (state_q == S_DONE);
  assign bus.err_invalid_o   = err_q[2];
  assign bus.err_overflow_o  = err_q[1];
  assign bus.err_underflow_o = err_q[0];
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - Scoreboard bench for fir_mac_sequencer with directed runs
module tb_fir_mac_sequencer;
  localparam int HW = 4;
  localparam int XW = 6;
  localparam int NT = 16;
  localparam int NS = 64;
  localparam int N_DIR = 9;
  // Hand-computed (n,k) probes: issue cycle 16n+k+1, x_addr=(n-k) mod 64, zero=(k>n).
  localparam int DIR_ISSUE [N_DIR] = '{1, 2, 16, 256, 242, 324, 1024, 19, 240};
  localparam int DIR_XADDR [N_DIR] = '{0, 63, 49, 0, 14, 17, 48, 63, 63};
  localparam int DIR_ZERO  [N_DIR] = '{0, 1, 1, 0, 0, 0, 0, 1, 1};

  typedef struct { int n; int at; } y_exp_t;
  typedef struct { int done_at; int r_cnt; int mac_cnt; int busy_cnt; int zero_cnt; int err; } run_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.H_ADDR_WIDTH(HW), .X_ADDR_WIDTH(XW)) bus ();

  fir_mac_sequencer #(
    .H_ADDR_WIDTH(HW), .X_ADDR_WIDTH(XW), .NUM_TAPS(NT), .NUM_SAMPLES(NS),
    .MEM_LATENCY(1), .DSP_LATENCY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  y_exp_t   y_q [$];
  run_exp_t run_q [$];

  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  int t = 0;
  bit end_req = 0;
  bit rst_d = 0;

  logic [25:0] out_vec;
  logic [2:0]  err_vec;
  assign err_vec = {bus.err_invalid_o, bus.err_overflow_o, bus.err_underflow_o};
  assign out_vec = {bus.R_en, bus.h_addr, bus.x_addr, bus.mac_en_o, bus.mac_first_o, bus.x_zero_o,
                    bus.y_valid_o, bus.y_index_o, bus.busy_o, bus.done_o, err_vec};

  always @(posedge clk) rst_d <= rst;

  int rc = 0, r_ph = 0, m_ph = 0, r_cnt = 0, mac_cnt = 0, busy_cnt = 0, zero_cnt = 0;
  int run_no = 0, last_err = 0;
  bit in_run = 0, quiet = 0, busy_prev = 0, final_done = 0;
  int xlog [1100];
  bit zlog [1100];
  y_exp_t   ye;
  run_exp_t re;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_d) begin
      chk("reset_outputs", int'(out_vec), 0);
      in_run = 0; quiet = 1; busy_prev = 0;
      r_ph = 0; m_ph = 0; last_err = 0;
    end else begin
      if (bus.busy_o && !busy_prev) begin
        in_run = 1; quiet = 0; rc = 0; run_no++;
        r_cnt = 0; mac_cnt = 0; busy_cnt = 0; zero_cnt = 0;
        chk("err_cleared_at_start", int'(err_vec), 0);
      end
      if (quiet) chk("quiet_after_reset", int'({bus.R_en, bus.mac_en_o, bus.y_valid_o}), 0);
      if (in_run) rc++;
      if (bus.R_en) begin
        chk("h_addr_seq", int'(bus.h_addr), r_ph);
        r_ph = (r_ph + 1) % NT;
        r_cnt++;
        if (run_no == 1 && rc < 1100) xlog[rc] = int'(bus.x_addr);
      end
      if (bus.mac_en_o) begin
        chk("mac_first", int'(bus.mac_first_o), (m_ph == 0) ? 1 : 0);
        m_ph = (m_ph + 1) % NT;
        mac_cnt++;
        if (bus.x_zero_o) zero_cnt++;
        if (run_no == 1 && rc < 1100) zlog[rc] = bus.x_zero_o;
      end
      if (in_run && bus.busy_o) busy_cnt++;
      if (!bus.busy_o && !bus.done_o) chk("err_hold_idle", int'(err_vec), last_err);
      if (bus.y_valid_o) begin
        chk("y_valid_pending", (y_q.size() > 0) ? 1 : 0, 1);
        if (y_q.size() > 0) begin
          ye = y_q.pop_front();
          chk("y_index", int'(bus.y_index_o), ye.n);
          chk("y_valid_cycle", rc, ye.at);
        end
      end
      if (bus.done_o) begin
        chk("done_pending_run", (in_run && run_q.size() > 0) ? 1 : 0, 1);
        if (run_q.size() > 0) begin
          re = run_q.pop_front();
          chk("done_cycle", rc, re.done_at);
          chk("r_en_count", r_cnt, re.r_cnt);
          chk("mac_en_count", mac_cnt, re.mac_cnt);
          chk("busy_cycles", busy_cnt, re.busy_cnt);
          chk("x_zero_count", zero_cnt, re.zero_cnt);
          chk("err_flags_at_done", int'(err_vec), re.err);
          last_err = re.err;
          if (run_no == 1) begin
            for (int i = 0; i < N_DIR; i++) begin
              chk("x_addr_probe", xlog[DIR_ISSUE[i]], DIR_XADDR[i]);
              chk("x_zero_probe", int'(zlog[DIR_ISSUE[i] + 1]), DIR_ZERO[i]);
            end
          end
        end
        in_run = 0;
      end
      busy_prev = bus.busy_o;
    end
    if (end_req && !final_done) begin
      chk("y_queue_drained", y_q.size(), 0);
      chk("run_queue_drained", run_q.size(), 0);
      chk("wait_timeouts", timeouts, 0);
      final_done = 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    t++;
  endtask

  task automatic start_run(input bit full, input int err_exp);
    y_exp_t   y;
    run_exp_t r;
    bus.start_i = 1'b1;
    for (int i = 0; i < NS; i++) begin
      y.n  = i;
      y.at = 16 * i + 21;
      y_q.push_back(y);
    end
    if (full) begin
      r.done_at  = 1030;
      r.r_cnt    = 1024;
      r.mac_cnt  = 1024;
      r.busy_cnt = 1029;
      r.zero_cnt = 120;
      r.err      = err_exp;
      run_q.push_back(r);
    end
    step();
    bus.start_i = 1'b0;
    t = 1;
  endtask

  task automatic wait_done();
    int lim = 0;
    while (!bus.done_o && lim < 1200) begin
      step();
      lim++;
    end
    if (!bus.done_o) timeouts++;
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus.invalid_i = 1'b0;
    bus.overflow_i = 1'b0;
    bus.underflow_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    bus.start_i = 1'b0;
    repeat (5) step();

    start_run(1'b1, 0);
    while (t < 500) step();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    wait_done();
    step();

    start_run(1'b0, 0);
    while (t < 300) step();
    rst = 1'b1;
    while (y_q.size() > 0 && y_q[y_q.size()-1].at > t) void'(y_q.pop_back());
    step();
    step();
    rst = 1'b0;
    repeat (40) step();

    start_run(1'b1, 3'b010);
    while (t < 101) step();
    bus.overflow_i = 1'b1;
    step();
    bus.overflow_i = 1'b0;
    wait_done();
    repeat (3) step();

    start_run(1'b1, 0);
    wait_done();
    step();
    end_req = 1'b1;
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
